// File: rtl/sha1_round_sequencer.sv
// sha1_round_sequencer: steps the SHA-1 round datapath through one chunk.
// Optional SHA1_SEQ_PERF_EN adds a saturating W-stall counter (stall_cnt).
module sha1_round_sequencer #(
    parameter int ROUNDS   = 80,
    parameter int QUAD_LEN = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        start_ready,
    input  logic        w_valid,
    output logic        wk_en,
    output logic [1:0]  round_type,
    output logic [1:0]  quad_funct,
    output logic [6:0]  rnd,
    output logic [31:0] k_out,
    output logic        busy,
    output logic        done
`ifdef SHA1_SEQ_PERF_EN
    ,
    output logic [15:0] stall_cnt
`endif
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_KERN,
        S_EPI,
        S_DONE
    } state_t;

    localparam logic [6:0] LAST = 7'(ROUNDS - 1);
    localparam logic [6:0] Q1   = 7'(QUAD_LEN);
    localparam logic [6:0] Q2   = 7'(2 * QUAD_LEN);
    localparam logic [6:0] Q3   = 7'(3 * QUAD_LEN);

    state_t     state;
    state_t     state_nx;
    logic [6:0] rnd_nx;

    // State and round index registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            rnd   <= '0;
        end else begin
            state <= state_nx;
            rnd   <= rnd_nx;
        end
    end

    // Next state, next round index and state-decoded outputs
    always_comb begin
        state_nx    = state;
        rnd_nx      = rnd;
        wk_en       = 1'b0;
        round_type  = 2'b00;
        busy        = 1'b1;
        done        = 1'b0;
        start_ready = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy        = 1'b0;
                start_ready = 1'b1;
                if (start) begin
                    state_nx = S_PRE;
                    rnd_nx   = '0;
                end
            end
            S_PRE: begin
                round_type = 2'b00;
                wk_en      = w_valid;
                if (w_valid) begin
                    state_nx = S_KERN;
                    rnd_nx   = 7'd1;
                end
            end
            S_KERN: begin
                round_type = 2'b01;
                wk_en      = w_valid;
                if (w_valid) begin
                    if (rnd == LAST) begin
                        state_nx = S_EPI;
                    end else begin
                        rnd_nx = rnd + 7'd1;
                    end
                end
            end
            S_EPI: begin
                round_type = 2'b10;
                state_nx   = S_DONE;
            end
            S_DONE: begin
                round_type  = 2'b11;
                done        = 1'b1;
                start_ready = 1'b1;
                if (start) begin
                    state_nx = S_PRE;
                    rnd_nx   = '0;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                rnd_nx   = '0;
            end
        endcase
    end

    // Quad group follows the registered round index
    always_comb begin
        if (rnd >= Q3) begin
            quad_funct = 2'd3;
        end else if (rnd >= Q2) begin
            quad_funct = 2'd2;
        end else if (rnd >= Q1) begin
            quad_funct = 2'd1;
        end else begin
            quad_funct = 2'd0;
        end
    end

    // Round constant for the current quad group
    always_comb begin
        unique case (quad_funct)
            2'd0: k_out = 32'h5A827999;
            2'd1: k_out = 32'h6ED9EBA1;
            2'd2: k_out = 32'h8F1BBCDC;
            2'd3: k_out = 32'hCA62C1D6;
        endcase
    end

`ifdef SHA1_SEQ_PERF_EN
    logic accept;
    logic waiting;

    assign accept  = start & start_ready;
    assign waiting = (state == S_PRE || state == S_KERN) && !w_valid;

    // Cycles lost waiting on W, cleared per accepted chunk, saturating
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            stall_cnt <= '0;
        end else if (waiting && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sha1_round_sequencer.sv
// tb_sha1_round_sequencer: table of chunk scenarios with a per-cycle
// expected-output queue for sha1_round_sequencer.
module tb_sha1_round_sequencer;
    localparam int ST_IDLE = 0;
    localparam int ST_PRE  = 1;
    localparam int ST_KERN = 2;
    localparam int ST_EPI  = 3;
    localparam int ST_DONE = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b1;
    logic        w_valid = 1'b1;
    logic        start_ready;
    logic        wk_en;
    logic [1:0]  round_type;
    logic [1:0]  quad_funct;
    logic [6:0]  rnd;
    logic [31:0] k_out;
    logic        busy;
    logic        done;
`ifdef SHA1_SEQ_PERF_EN
    logic [15:0] stall_cnt;
`endif

    sha1_round_sequencer #(.ROUNDS(80), .QUAD_LEN(20)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .start_ready(start_ready),
        .w_valid(w_valid),
        .wk_en(wk_en),
        .round_type(round_type),
        .quad_funct(quad_funct),
        .rnd(rnd),
        .k_out(k_out),
        .busy(busy),
        .done(done)
`ifdef SHA1_SEQ_PERF_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  rt;
        logic [1:0]  quad;
        logic [6:0]  rnd;
        logic [31:0] k;
        logic        wk;
        logic        busy;
        logic        done;
        logic        sr;
    } exp_t;

    typedef struct {
        int pre_stall;
        int stall_rnd;
        int nstall;
        bit start_busy;
        int abort_rnd;
        int exp_lat;
        int exp_stall;
    } scen_t;

    typedef struct {
        int          r;
        logic [1:0]  quad;
        logic [31:0] k;
    } qk_t;

    logic [31:0] ktab [4] = '{32'h5A827999, 32'h6ED9EBA1,
                              32'h8F1BBCDC, 32'hCA62C1D6};

    exp_t  sb[$];
    exp_t  got;
    logic [15:0] got_stall;
    int    n_checks = 0;
    int    n_fail = 0;
    int    last_rnd = 0;
    bit    chained = 1'b0;
    scen_t scen [8];
    qk_t   qt [7];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int st, input int r, input bit wk);
        exp_t e;
        int   q;
        q      = r / 20;
        e.rt   = (st == ST_IDLE) ? 2'd0 : 2'(st - 1);
        e.quad = 2'(q);
        e.rnd  = 7'(r);
        e.k    = ktab[q];
        e.wk   = wk;
        e.busy = (st != ST_IDLE);
        e.done = (st == ST_DONE);
        e.sr   = (st == ST_IDLE) || (st == ST_DONE);
        return e;
    endfunction

    task automatic cyc(input bit rs, input bit st, input bit wv,
                       input exp_t e, input string tag);
        exp_t x;
        reset   = rs;
        start   = st;
        w_valid = wv;
        sb.push_back(e);
        @(negedge clk);
        got = {round_type, quad_funct, rnd, k_out,
               wk_en, busy, done, start_ready};
`ifdef SHA1_SEQ_PERF_EN
        got_stall = stall_cnt;
`else
        got_stall = 16'd0;
`endif
        x = sb.pop_front();
        chk(tag, 64'(got), 64'(x));
        @(posedge clk);
        #1;
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run(input scen_t s, input bit qchk);
        int c;
        bit sb_in;
        c     = 0;
        sb_in = s.start_busy;
        if (!chained) begin
            cyc(0, 1, rb(), mk(ST_IDLE, last_rnd, 0), "idle start");
        end
        for (int i = 0; i < s.pre_stall; i++) begin
            c++;
            cyc(0, sb_in, 0, mk(ST_PRE, 0, 0), "pre stall");
        end
        c++;
        cyc(0, sb_in, 1, mk(ST_PRE, 0, 1), "pre");
        for (int r = 1; r < 80; r++) begin
            if (r == s.stall_rnd) begin
                for (int i = 0; i < s.nstall; i++) begin
                    c++;
                    cyc(0, sb_in, 0, mk(ST_KERN, r, 0),
                        $sformatf("kern stall r%0d", r));
                end
            end
            if (r == s.abort_rnd) begin
                cyc(1, 0, 1, mk(ST_KERN, r, 1), "kern at reset");
                for (int i = 0; i < 4; i++) begin
                    cyc(0, 0, rb(), mk(ST_IDLE, 0, 0), "after abort");
                end
`ifdef SHA1_SEQ_PERF_EN
                chk("stall_cnt after reset", 64'(got_stall), 64'd0);
`endif
                last_rnd = 0;
                chained  = 1'b0;
                return;
            end
            c++;
            cyc(0, sb_in, 1, mk(ST_KERN, r, 1), $sformatf("kern r%0d", r));
            if (qchk) begin
                for (int j = 0; j < 7; j++) begin
                    if (qt[j].r == r) begin
                        chk($sformatf("quad_funct r%0d", r),
                            64'(got.quad), 64'(qt[j].quad));
                        chk($sformatf("k_out r%0d", r),
                            64'(got.k), 64'(qt[j].k));
                    end
                end
            end
        end
        c++;
        cyc(0, sb_in, rb(), mk(ST_EPI, 79, 0), "epi");
        c++;
        cyc(0, sb_in, rb(), mk(ST_DONE, 79, 0), "done");
        chk("latency to done", 64'(c), 64'(s.exp_lat));
`ifdef SHA1_SEQ_PERF_EN
        chk("stall_cnt at done", 64'(got_stall), 64'(s.exp_stall));
`endif
        last_rnd = 79;
        chained  = sb_in;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        scen[0] = '{0, 0, 0, 1'b0, 0, 82, 0};
        scen[1] = '{0, 45, 3, 1'b0, 0, 85, 3};
        scen[2] = '{5, 0, 0, 1'b0, 0, 87, 5};
        scen[3] = '{0, 0, 0, 1'b1, 0, 82, 0};
        scen[4] = '{0, 30, 2, 1'b1, 0, 84, 2};
        scen[5] = '{0, 0, 0, 1'b0, 0, 82, 0};
        scen[6] = '{0, 0, 0, 1'b0, 50, -1, 0};
        scen[7] = '{0, 0, 0, 1'b0, 0, 82, 0};

        qt[0] = '{19, 2'd0, 32'h5A827999};
        qt[1] = '{20, 2'd1, 32'h6ED9EBA1};
        qt[2] = '{39, 2'd1, 32'h6ED9EBA1};
        qt[3] = '{40, 2'd2, 32'h8F1BBCDC};
        qt[4] = '{59, 2'd2, 32'h8F1BBCDC};
        qt[5] = '{60, 2'd3, 32'hCA62C1D6};
        qt[6] = '{79, 2'd3, 32'hCA62C1D6};

        // reset held with start high: start must be lost
        repeat (2) @(posedge clk);
        #1;
        cyc(0, 0, rb(), mk(ST_IDLE, 0, 0), "reset state");
        cyc(0, 0, rb(), mk(ST_IDLE, 0, 0), "idle hold");
`ifdef SHA1_SEQ_PERF_EN
        chk("stall_cnt reset", 64'(got_stall), 64'd0);
`endif

        for (int i = 0; i < 8; i++) begin
            run(scen[i], i == 0);
        end

        cyc(0, 0, rb(), mk(ST_IDLE, 79, 0), "final idle");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sha1_round_sequencer.md
Name: sha1_round_sequencer

Overview:
- Sequences the single-round pipelined SHA-1 hash datapath through one 512-bit chunk.
- Drives round_type, quad_funct, round index and K constant for each cycle.
- Stalls when the message-schedule W word is not yet valid.
- Sits between the chunk/nonce control FSM (start handshake) and the hash datapath plus W-schedule unit.

Parameters:
ROUNDS, 80, total SHA-1 rounds per chunk; must be a multiple of QUAD_LEN
QUAD_LEN, 20, rounds per quad_funct group

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request to hash one chunk; accepted when start & start_ready
start_ready  out  1  sequencer can accept start this cycle
w_valid  in  1  W word for index rnd is available this cycle
wk_en  out  1  datapath/W-schedule consume W[rnd]+K this cycle (advance)
round_type  out  2  00 PRECOMPUTE, 01 KERNEL, 10 EPILOGUE, 11 CHUNK_DONE
quad_funct  out  2  rnd / QUAD_LEN
rnd  out  7  W/K round index presented this cycle
k_out  out  32  SHA-1 constant for quad_funct
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in CHUNK_DONE

Behaviour:
- Reset values: state IDLE, rnd=0, round_type=00, quad_funct=00, k_out=32'h5A827999, wk_en=0, busy=0, done=0, start_ready=1.
- States and transitions:
  - IDLE: start_ready=1. On start, next state PRE.
  - PRE: round_type=PRECOMPUTE, rnd=0, wk_en=w_valid. Holds while !w_valid. On w_valid, next state KERN with rnd=1.
  - KERN: round_type=KERNEL, wk_en=w_valid. On w_valid, rnd increments. When rnd==ROUNDS-1 and w_valid, next state EPI. While !w_valid, state, rnd and all outputs hold.
  - EPI: round_type=EPILOGUE, rnd holds at ROUNDS-1, wk_en=0. Never stalls. Next state DONE.
  - DONE: round_type=CHUNK_DONE, done=1, start_ready=1, wk_en=0. If start this cycle, next state PRE (back-to-back chunk) with rnd=0; otherwise next state IDLE.
- Latency, no stalls: start accepted in cycle T. PRE at T+1, KERN at T+2..T+80, EPI at T+81, done at T+82. Each stall cycle adds one cycle.
- quad_funct = rnd/QUAD_LEN: 0..19→0, 20..39→1, 40..59→2, 60..79→3. Generated combinationally from rnd or registered alongside it; it must always match rnd in the same cycle.
- k_out by quad: 0→5A827999, 1→6ED9EBA1, 2→8F1BBCDC, 3→CA62C1D6.
- start_ready=0 in PRE/KERN/EPI; start is ignored in those states and no request is queued.
- In IDLE, EPI and DONE, w_valid is don't-care.
- rnd never exceeds ROUNDS-1 and never wraps within a chunk. It returns to 0 only on entry to PRE or on reset.
- Reset asserted in any state: next cycle all outputs take reset values; an in-flight chunk is abandoned with no done pulse.
- Reset and start in the same cycle: reset wins; start is lost.
- All outputs are registered or decoded from registered state only. No combinational path from start or w_valid to any output except wk_en (direct AND with w_valid in PRE/KERN).

Optional Feature:
- Macro SHA1_SEQ_PERF_EN.
- Defined: adds output stall_cnt (16 bits). It clears on reset and on each start acceptance, and increments every PRE/KERN cycle with w_valid=0, saturating at 16'hFFFF. Its value holds after done until the next accepted start.
- Undefined: stall_cnt port absent, no counter logic.

Test Plan:
- Reset, start=1 one cycle, w_valid=1 always -> PRE at cycle 1, rnd steps 1..79 over KERN cycles 2..80, EPI at 81, done=1 only at cycle 82, start_ready=0 in cycles 1..81.
- Same run, sample at rnd 19/20/39/40/59/60/79 -> quad_funct 0/1/1/2/2/3/3; k_out 5A827999/6ED9EBA1/6ED9EBA1/8F1BBCDC/8F1BBCDC/CA62C1D6/CA62C1D6.
- w_valid=0 for 3 cycles at rnd=45 -> rnd, round_type and k_out hold, wk_en=0 for those cycles; done arrives at cycle 85; stall_cnt=3 if SHA1_SEQ_PERF_EN.
- start held high continuously -> DONE goes directly to PRE with rnd=0, no IDLE cycle, chunk period exactly 82 cycles; start pulses while busy are ignored.
- reset asserted at rnd=50 -> next cycle IDLE, rnd=0, busy=0, start_ready=1, no done pulse; a following start runs a full 82-cycle chunk.
- w_valid=0 during PRE for 5 cycles -> round_type stays 00, rnd=0, wk_en=0; KERN begins the cycle after w_valid=1.
